// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU bus cycle controller.
// Slot decode helper resolves multi-hot chipselects to the lowest index.
package cpu_bus_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 3;
    localparam int DEV_AW    = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ERROR = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [SLOT_W-1:0] lowest_slot(input logic [NUM_SLOTS-1:0] cs);
        logic found;
        lowest_slot = '0;
        found       = 1'b0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (cs[i] && !found) begin
                lowest_slot = SLOT_W'(i);
                found       = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/cpu_bus_controller_sync2.sv
// Two-flop synchroniser for signals crossing from the slower core clock domain.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cpu_bus_controller.sv
// Bus cycle controller: turns synchronised core strobes into one slot request
// per bus cycle and returns DTACK on ack / wait-state expiry, or BERR.
module cpu_bus_controller
    import cpu_bus_pkg::*;
#(
    parameter int          TIMEOUT     = 255,
    parameter logic [7:0]  WAIT_MASK   = 8'h03,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          cpu_addr,
    input  logic [15:0]          cpu_dataout,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    input  logic                 cpu_uds,
    input  logic                 cpu_lds,
    input  logic [NUM_SLOTS-1:0] chipselects,
    output logic [15:0]          cpu_datain,
    output logic                 cpu_dtack,
    output logic                 cpu_berr,
    output logic [NUM_SLOTS-1:0] dev_req,
    output logic                 dev_we,
    output logic [1:0]           dev_be,
    output logic [DEV_AW-1:0]    dev_addr,
    output logic [15:0]          dev_wdata,
    input  logic [15:0]          dev_rdata,
    input  logic [NUM_SLOTS-1:0] dev_ack
);

    localparam int CW = 16;

    logic              rd_s;
    logic              wr_s;
    logic              uds_s;
    logic              lds_s;
    logic              strobe;
    logic              strobe_d;
    logic              done_now;
    logic              unused_addr;
    state_t            state;
    logic [SLOT_W-1:0] slot;
    logic [CW-1:0]     count;

    sync2 #(.WIDTH(4)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({cpu_read, cpu_write, cpu_uds, cpu_lds}),
        .q   ({rd_s, wr_s, uds_s, lds_s})
    );

    assign strobe      = rd_s | wr_s;
    assign unused_addr = ^cpu_addr[31:DEV_AW];

    // Wait-state slots ignore dev_ack entirely; ack slots ignore the counter.
    always_comb begin
        done_now = 1'b0;
        if (WAIT_MASK[slot]) begin
            done_now = (count == CW'(WAIT_CYCLES));
        end else begin
            done_now = dev_ack[slot];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            strobe_d   <= 1'b0;
            slot       <= '0;
            count      <= '0;
            cpu_datain <= '0;
            cpu_dtack  <= 1'b0;
            cpu_berr   <= 1'b0;
            dev_req    <= '0;
            dev_we     <= 1'b0;
            dev_be     <= '0;
            dev_addr   <= '0;
            dev_wdata  <= '0;
        end else begin
            dev_req  <= '0;
            strobe_d <= strobe;
            case (state)
                IDLE: begin
                    count <= '0;
                    if (strobe && !strobe_d && (uds_s || lds_s)) begin
                        dev_addr  <= cpu_addr[DEV_AW-1:0];
                        dev_wdata <= cpu_dataout;
                        dev_we    <= wr_s;
                        dev_be    <= {uds_s, lds_s};
                        slot      <= lowest_slot(chipselects);
                        if ((rd_s && wr_s) || (chipselects == '0)) begin
                            state <= ERROR;
                        end else begin
                            dev_req <= NUM_SLOTS'(1) << lowest_slot(chipselects);
                            state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    count <= count + 1'b1;
                    if (!strobe) begin
                        state <= IDLE;
                    end else if (done_now) begin
                        if (!dev_we) begin
                            cpu_datain <= dev_rdata;
                        end
                        cpu_dtack <= 1'b1;
                        state     <= DONE;
                    end else if (count == CW'(TIMEOUT)) begin
                        state <= ERROR;
                    end
                end
                ERROR: begin
                    cpu_berr <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    if (!strobe) begin
                        cpu_dtack <= 1'b0;
                        cpu_berr  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_controller.sv
// Randomised bench for cpu_bus_controller with a transaction-level reference model.
module tb_cpu_bus_controller;

    localparam int         TO = 255;
    localparam logic [7:0] WM = 8'h01;
    localparam int         WC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr;
    logic [15:0] cpu_dataout;
    logic        cpu_read;
    logic        cpu_write;
    logic        cpu_uds;
    logic        cpu_lds;
    logic [7:0]  chipselects;
    logic [15:0] cpu_datain;
    logic        cpu_dtack;
    logic        cpu_berr;
    logic [7:0]  dev_req;
    logic        dev_we;
    logic [1:0]  dev_be;
    logic [23:0] dev_addr;
    logic [15:0] dev_wdata;
    logic [15:0] dev_rdata;
    logic [7:0]  dev_ack;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_datain;
    int          r_t;
    int          r_p;
    logic [7:0]  r_val;
    logic        r_we;
    logic [1:0]  r_be;
    logic [23:0] r_addr;
    logic [15:0] r_wdata;
    int          s_t;
    logic        s_dt;
    logic        s_berr;
    logic        held;
    logic        cleared;

    cpu_bus_controller #(
        .TIMEOUT     (TO),
        .WAIT_MASK   (WM),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_addr    (cpu_addr),
        .cpu_dataout (cpu_dataout),
        .cpu_read    (cpu_read),
        .cpu_write   (cpu_write),
        .cpu_uds     (cpu_uds),
        .cpu_lds     (cpu_lds),
        .chipselects (chipselects),
        .cpu_datain  (cpu_datain),
        .cpu_dtack   (cpu_dtack),
        .cpu_berr    (cpu_berr),
        .dev_req     (dev_req),
        .dev_we      (dev_we),
        .dev_be      (dev_be),
        .dev_addr    (dev_addr),
        .dev_wdata   (dev_wdata),
        .dev_rdata   (dev_rdata),
        .dev_ack     (dev_ack)
    );

    always #20 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle;
        cpu_addr    = '0;
        cpu_dataout = '0;
        cpu_read    = 1'b0;
        cpu_write   = 1'b0;
        cpu_uds     = 1'b0;
        cpu_lds     = 1'b0;
        chipselects = '0;
        dev_rdata   = '0;
        dev_ack     = '0;
    endtask

    // Core-side stimulus plus a simple slave: acks its own req line after ack_delay
    // cycles (negative = never) and pulses acks on every other slot as noise.
    task automatic do_cycle(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [15:0] d, input logic u, input logic l,
                            input logic [7:0] cs, input int ack_delay,
                            input logic [15:0] rdata, input int budget);
        r_t = -1; r_p = 0; r_val = '0; r_we = 1'b0; r_be = '0; r_addr = '0; r_wdata = '0;
        s_t = -1; s_dt = 1'b0; s_berr = 1'b0;
        dev_rdata   = rdata;
        cpu_addr    = a;
        cpu_dataout = d;
        cpu_uds     = u;
        cpu_lds     = l;
        chipselects = cs;
        cpu_read    = rd;
        cpu_write   = wr;
        dev_ack     = '0;
        for (int t = 1; t <= budget && s_t < 0; t++) begin
            tick;
            if (dev_req != '0) begin
                r_p++;
                if (r_t < 0) begin
                    r_t = t; r_val = dev_req; r_we = dev_we; r_be = dev_be;
                    r_addr = dev_addr; r_wdata = dev_wdata;
                end
            end
            if (cpu_dtack || cpu_berr) begin
                s_t = t; s_dt = cpu_dtack; s_berr = cpu_berr;
            end
            dev_ack = '0;
            if (r_t >= 0 && ack_delay >= 0 && t == r_t + ack_delay) dev_ack = r_val;
            else if (r_t >= 0 && ack_delay >= 1 && t == r_t) dev_ack = ~r_val;
        end
        dev_ack = '0;
    endtask

    task automatic release_strobes;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        tick;
        tick;
        held = cpu_dtack | cpu_berr;
        tick;
        cleared = !(cpu_dtack || cpu_berr);
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive_idle();
        tick;
        tick;
        checks++;
        if ({cpu_dtack, cpu_berr, dev_req, dev_we, dev_be} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got dtack=%b berr=%b req=%h we=%b be=%b expected all 0",
                     cpu_dtack, cpu_berr, dev_req, dev_we, dev_be);
        end
        checks++;
        if ({cpu_datain, dev_addr, dev_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: got datain=%h addr=%h wdata=%h expected 0",
                     cpu_datain, dev_addr, dev_wdata);
        end
        rst = 1'b0;
        tick;
        exp_datain = '0;
    endtask

    task automatic test_wait_read;
        do_cycle(1'b1, 1'b0, 32'h0000_1000, 16'h0000, 1'b1, 1'b1, 8'h01, -1, 16'h4E71, 40);
        checks++;
        if (r_val !== 8'h01 || r_p != 1 || r_t != 3) begin
            errors++;
            $display("FAIL wait_read_req: got req=%h pulses=%0d at=%0d expected 01 1 3", r_val, r_p, r_t);
        end
        checks++;
        if (r_we !== 1'b0 || r_be !== 2'b11 || r_addr !== 24'h001000) begin
            errors++;
            $display("FAIL wait_read_fields: got we=%b be=%b addr=%h expected 0 11 001000", r_we, r_be, r_addr);
        end
        checks++;
        if (s_dt !== 1'b1 || s_berr !== 1'b0 || s_t != 3 + WC + 1) begin
            errors++;
            $display("FAIL wait_read_dtack: got dtack=%b berr=%b at=%0d expected 1 0 %0d", s_dt, s_berr, s_t, 3 + WC + 1);
        end
        checks++;
        if (cpu_datain !== 16'h4E71) begin
            errors++;
            $display("FAIL wait_read_data: got %h expected 4e71", cpu_datain);
        end
        release_strobes();
        checks++;
        if (held !== 1'b1 || cleared !== 1'b1) begin
            errors++;
            $display("FAIL wait_read_release: got held=%b cleared=%b expected 1 1", held, cleared);
        end
        checks++;
        if (cpu_datain !== 16'h4E71) begin
            errors++;
            $display("FAIL wait_read_hold: got %h expected 4e71", cpu_datain);
        end
        exp_datain = 16'h4E71;
    endtask

    task automatic test_ack_write;
        do_cycle(1'b0, 1'b1, 32'hFF12_3456, 16'hBEEF, 1'b1, 1'b0, 8'h02, 2, 16'h1111, 40);
        checks++;
        if (r_val !== 8'h02 || r_we !== 1'b1 || r_be !== 2'b10) begin
            errors++;
            $display("FAIL ack_write_req: got req=%h we=%b be=%b expected 02 1 10", r_val, r_we, r_be);
        end
        checks++;
        if (r_wdata !== 16'hBEEF || r_addr !== 24'h123456) begin
            errors++;
            $display("FAIL ack_write_data: got wdata=%h addr=%h expected beef 123456", r_wdata, r_addr);
        end
        checks++;
        if (s_dt !== 1'b1 || s_t != r_t + 3) begin
            errors++;
            $display("FAIL ack_write_dtack: got dtack=%b at=%0d expected 1 %0d", s_dt, s_t, r_t + 3);
        end
        checks++;
        if (cpu_datain !== exp_datain) begin
            errors++;
            $display("FAIL ack_write_datain: got %h expected %h", cpu_datain, exp_datain);
        end
        release_strobes();
        checks++;
        if (held !== 1'b1 || cleared !== 1'b1) begin
            errors++;
            $display("FAIL ack_write_release: got held=%b cleared=%b expected 1 1", held, cleared);
        end
    endtask

    task automatic test_no_slot;
        do_cycle(1'b1, 1'b0, 32'h00F0_0000, 16'h0000, 1'b1, 1'b1, 8'h00, 0, 16'h2222, 20);
        checks++;
        if (r_p != 0) begin
            errors++;
            $display("FAIL no_slot_req: got %0d pulses expected 0", r_p);
        end
        checks++;
        if (s_berr !== 1'b1 || s_dt !== 1'b0 || s_t != 4) begin
            errors++;
            $display("FAIL no_slot_berr: got berr=%b dtack=%b at=%0d expected 1 0 4", s_berr, s_dt, s_t);
        end
        release_strobes();
        checks++;
        if (held !== 1'b1 || cleared !== 1'b1) begin
            errors++;
            $display("FAIL no_slot_release: got held=%b cleared=%b expected 1 1", held, cleared);
        end
    endtask

    task automatic test_timeout;
        do_cycle(1'b1, 1'b0, 32'h0030_0000, 16'h0000, 1'b0, 1'b1, 8'h08, -1, 16'h3333, TO + 50);
        checks++;
        if (r_val !== 8'h08 || r_t != 3) begin
            errors++;
            $display("FAIL timeout_req: got req=%h at=%0d expected 08 3", r_val, r_t);
        end
        checks++;
        if (s_berr !== 1'b1 || s_dt !== 1'b0 || s_t != r_t + TO + 2) begin
            errors++;
            $display("FAIL timeout_berr: got berr=%b dtack=%b at=%0d expected 1 0 %0d", s_berr, s_dt, s_t, r_t + TO + 2);
        end
        release_strobes();
        checks++;
        if (held !== 1'b1 || cleared !== 1'b1) begin
            errors++;
            $display("FAIL timeout_release: got held=%b cleared=%b expected 1 1", held, cleared);
        end
    endtask

    task automatic test_abort;
        logic seen;
        logic stray;
        seen = 1'b0;
        stray = 1'b0;
        cpu_addr = 32'h0020_0000; cpu_uds = 1'b1; cpu_lds = 1'b1; chipselects = 8'h04;
        dev_rdata = 16'hDEAD; cpu_read = 1'b1;
        for (int t = 0; t < 10 && !seen; t++) begin
            tick;
            if (dev_req != '0) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL abort_req: got no dev_req in 10 cycles expected one");
        end
        cpu_read = 1'b0;
        tick; tick; tick;
        dev_ack = 8'h04;
        tick;
        if (cpu_dtack || cpu_berr || dev_req != '0) stray = 1'b1;
        dev_ack = '0;
        for (int t = 0; t < 6; t++) begin
            tick;
            if (cpu_dtack || cpu_berr || dev_req != '0) stray = 1'b1;
        end
        checks++;
        if (stray !== 1'b0) begin
            errors++;
            $display("FAIL abort_late_ack: got activity=%b expected 0", stray);
        end
        do_cycle(1'b1, 1'b0, 32'h0020_0002, 16'h0000, 1'b1, 1'b1, 8'h04, 1, 16'h1234, 40);
        checks++;
        if (s_dt !== 1'b1 || s_t != 5 || cpu_datain !== 16'h1234) begin
            errors++;
            $display("FAIL abort_recover: got dtack=%b at=%0d data=%h expected 1 5 1234", s_dt, s_t, cpu_datain);
        end
        exp_datain = 16'h1234;
        release_strobes();
    endtask

    task automatic test_back_to_back;
        logic        rd, wr, u, l, active, err, is_wait, found;
        logic [7:0]  cs, exp_req;
        logic [31:0] a;
        logic [15:0] d, rdata;
        int          delay, slot, exp_t, sel;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            rd = (sel <= 5); wr = (sel == 0) || (sel >= 6);
            sel = $urandom_range(0, 15);
            {u, l} = (sel == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            cs = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            a = $urandom; d = 16'($urandom); rdata = 16'($urandom);
            delay = $urandom_range(0, 6);

            slot = 0; found = 1'b0;
            for (int i = 0; i < 8; i++) if (cs[i] && !found) begin slot = i; found = 1'b1; end
            active  = u | l;
            err     = active && ((rd && wr) || cs == 8'h00);
            is_wait = WM[slot];
            exp_req = (active && !err) ? (8'h01 << slot) : 8'h00;
            if (!active) exp_t = -1;
            else if (err) exp_t = 4;
            else if (is_wait) exp_t = 3 + WC + 1;
            else exp_t = 3 + delay + 1;
            if (active && !err && rd) exp_datain = rdata;

            do_cycle(rd, wr, a, d, u, l, cs, delay, rdata, active ? 40 : 12);
            checks++;
            if (r_val !== exp_req || (exp_req != 0 && (r_t != 3 || r_p != 1))) begin
                errors++;
                $display("FAIL rand%0d_req: got req=%h at=%0d pulses=%0d expected %h at 3", n, r_val, r_t, r_p, exp_req);
            end
            if (exp_req != 0) begin
                checks++;
                if (r_we !== wr || r_be !== {u, l} || r_addr !== a[23:0] || (wr && r_wdata !== d)) begin
                    errors++;
                    $display("FAIL rand%0d_fields: got we=%b be=%b addr=%h wdata=%h expected %b %b %h %h",
                             n, r_we, r_be, r_addr, r_wdata, wr, {u, l}, a[23:0], d);
                end
            end
            checks++;
            if (s_t != exp_t || s_berr !== (active && err) || s_dt !== (active && !err)) begin
                errors++;
                $display("FAIL rand%0d_resp: got at=%0d dtack=%b berr=%b expected at=%0d dtack=%b berr=%b",
                         n, s_t, s_dt, s_berr, exp_t, active && !err, active && err);
            end
            checks++;
            if (cpu_datain !== exp_datain) begin
                errors++;
                $display("FAIL rand%0d_datain: got %h expected %h", n, cpu_datain, exp_datain);
            end
            release_strobes();
            if (active) begin
                checks++;
                if (held !== 1'b1 || cleared !== 1'b1) begin
                    errors++;
                    $display("FAIL rand%0d_release: got held=%b cleared=%b expected 1 1", n, held, cleared);
                end
            end
        end
    endtask

    task automatic test_reset_in_done;
        do_cycle(1'b1, 1'b0, 32'h0000_0040, 16'h0000, 1'b1, 1'b1, 8'h01, -1, 16'hA5A5, 40);
        checks++;
        if (s_dt !== 1'b1 || cpu_datain !== 16'hA5A5) begin
            errors++;
            $display("FAIL rst_done_setup: got dtack=%b data=%h expected 1 a5a5", s_dt, cpu_datain);
        end
        rst = 1'b1;
        drive_idle();
        tick;
        checks++;
        if ({cpu_datain, cpu_dtack, cpu_berr, dev_req, dev_we, dev_be, dev_addr, dev_wdata} !== '0) begin
            errors++;
            $display("FAIL rst_done_clear: got datain=%h dtack=%b berr=%b req=%h we=%b be=%b addr=%h wdata=%h expected 0",
                     cpu_datain, cpu_dtack, cpu_berr, dev_req, dev_we, dev_be, dev_addr, dev_wdata);
        end
        rst = 1'b0;
        tick; tick; tick;
        exp_datain = '0;
    endtask

    initial begin
        test_reset();
        test_wait_read();
        test_ack_write();
        test_no_slot();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_reset_in_done();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
